display_sequencer: RTL and testbench

Controller that sequences the five-digit seven-segment display path of the ARM processor board. It buffers up to DEPTH (value, letter) entries written by the processor's memory-mapped I/O. It rotates through them, presenting one entry for DWELL clock cycles on the num/letter inputs of the display decoder that drives disp4..disp0. When empty, it blanks the displays.

---
 rtl/display_pkg.sv | 24 ++
 rtl/display_sequencer_dwell_timer.sv | 30 +++
 rtl/display_sequencer.sv | 140 ++++++++++++++
 tb/tb_display_sequencer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared letter codes, FSM state and slot entry layout for the seven-segment
// display sequencer.
package display_pkg;

  localparam logic [3:0] LTR_A     = 4'h0;
  localparam logic [3:0] LTR_B     = 4'h1;
  localparam logic [3:0] LTR_C     = 4'h2;
  localparam logic [3:0] LTR_D     = 4'h3;
  localparam logic [3:0] LTR_E     = 4'h4;
  localparam logic [3:0] LTR_F     = 4'h5;
  localparam logic [3:0] LTR_P     = 4'h6;
  localparam logic [3:0] LTR_BLANK = 4'hF;

  typedef enum logic {
    EMPTY,
    SHOW
  } state_t;

  typedef struct packed {
    logic [3:0] letter;
    logic [7:0] num;
  } entry_t;

endpackage

// File: rtl/display_sequencer_dwell_timer.sv
// Loadable down-counter that measures how long one entry stays on the display;
// it parks at zero until reloaded.
module dwell_timer #(
  parameter int unsigned W        = 2,
  parameter logic [W-1:0] LOAD_VAL = '1
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic zero_o
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= LOAD_VAL;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/display_sequencer.sv
// Buffers (value, letter) entries from the processor and rotates through them
// on the display decoder inputs, DWELL cycles per entry; blanks when empty.
module display_sequencer
  import display_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DWELL = 50_000_000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [7:0]               wr_num,
  input  logic [3:0]               wr_letter,
  input  logic                     clear,
  input  logic                     hold,
  output logic [7:0]               num,
  output logic [3:0]               letter,
  output logic                     valid,
  output logic [$clog2(DEPTH)-1:0] idx,
  output logic                     full,
  output logic                     overflow
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = $clog2(DWELL);
  localparam logic [DW-1:0] RELOAD = DW'(DWELL - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic            ovf_q, ovf_d;
  logic            valid_q, valid_d;
  entry_t          shown_q, shown_d;
  entry_t          slot_q [DEPTH];

  logic            full_w, write_ok, slot_we;
  logic            tmr_load, tmr_en, tmr_zero;

  assign full_w   = (count_q == CW'(DEPTH));
  assign write_ok = wr_en && !full_w;

  dwell_timer #(
    .W       (DW),
    .LOAD_VAL(RELOAD)
  ) u_dwell (
    .clk   (clk),
    .reset (reset),
    .load_i(tmr_load),
    .en_i  (tmr_en),
    .zero_o(tmr_zero)
  );

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    ptr_d    = ptr_q;
    ovf_d    = ovf_q;
    slot_we  = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;

    if (clear) begin
      state_d = EMPTY;
      count_d = '0;
      ptr_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      if (wr_en && full_w) ovf_d = 1'b1;
      if (write_ok) begin
        slot_we = 1'b1;
        count_d = count_q + CW'(1);
      end
      case (state_q)
        EMPTY: begin
          if (write_ok) begin
            state_d  = SHOW;
            ptr_d    = '0;
            tmr_load = 1'b1;
          end
        end
        SHOW: begin
          // Wrap decision uses the pre-write count; a new entry waits a pass.
          if (!hold) begin
            if (tmr_zero) begin
              ptr_d    = ({1'b0, ptr_q} == count_q - CW'(1)) ? '0 : ptr_q + PW'(1);
              tmr_load = 1'b1;
            end else begin
              tmr_en = 1'b1;
            end
          end
        end
        default: ;
      endcase
    end

    valid_d = (state_d == SHOW);
    if (state_d == EMPTY) begin
      shown_d = '{letter: LTR_BLANK, num: 8'h00};
    end else if (state_q == EMPTY) begin
      shown_d = '{letter: wr_letter, num: wr_num};
    end else begin
      shown_d = slot_q[ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= EMPTY;
      count_q <= '0;
      ptr_q   <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
      shown_q <= '{letter: LTR_BLANK, num: 8'h00};
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
      shown_q <= shown_d;
    end
  end

  // NOTE: slot storage is deliberately not reset; count gates every read, so
  // stale contents are never visible.
  always_ff @(posedge clk) begin
    if (slot_we) slot_q[count_q[PW-1:0]] <= '{letter: wr_letter, num: wr_num};
  end

  assign num      = shown_q.num;
  assign letter   = shown_q.letter;
  assign valid    = valid_q;
  assign idx      = ptr_q;
  assign full     = full_w;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Scoreboard bench for display_sequencer with DEPTH=4, DWELL=4: expected
// per-cycle outputs are queued with the stimulus and popped after each edge.
module tb_display_sequencer;
  import display_pkg::*;

  typedef struct packed {
    logic       valid;
    logic [7:0] num;
    logic [3:0] letter;
    logic [1:0] idx;
    logic       full;
    logic       ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_num = 8'h00;
  logic [3:0] wr_letter = 4'h0;
  logic       clear = 1'b0;
  logic       hold = 1'b0;
  logic [7:0] num;
  logic [3:0] letter;
  logic       valid;
  logic [1:0] idx;
  logic       full;
  logic       overflow;

  int tests_run = 0;
  int tests_failed = 0;
  exp_t sb[$];

  display_sequencer #(.DEPTH(4), .DWELL(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_num   (wr_num),
    .wr_letter(wr_letter),
    .clear    (clear),
    .hold     (hold),
    .num      (num),
    .letter   (letter),
    .valid    (valid),
    .idx      (idx),
    .full     (full),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(logic v, logic [7:0] n, logic [3:0] l,
                              logic [1:0] i, logic f, logic o);
    return '{valid: v, num: n, letter: l, idx: i, full: f, ovf: o};
  endfunction

  function automatic exp_t observe();
    return '{valid: valid, num: num, letter: letter, idx: idx, full: full, ovf: overflow};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_write(logic en, logic [7:0] n, logic [3:0] l);
    wr_en = en;
    wr_num = n;
    wr_letter = l;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e, o;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) sb.push_back(mk(0, 8'h00, LTR_BLANK, 0, 0, 0));
    for (int i = 0; i < 10; i++) begin
      tick();
      e = sb.pop_front();
      o = observe();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL reset_idle cyc%0d: got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_single();
    exp_t e, o;
    do_clear();
    for (int i = 0; i < 12; i++) sb.push_back(mk(1, 8'd4, LTR_A, 0, 0, 0));
    for (int i = 0; i < 12; i++) begin
      if (i == 0) set_write(1, 8'd4, LTR_A);
      tick();
      set_write(0, 8'h00, 4'h0);
      e = sb.pop_front();
      o = observe();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL single cyc%0d: got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_three();
    exp_t e, o;
    logic [3:0] ltrs [3];
    ltrs[0] = LTR_B; ltrs[1] = LTR_C; ltrs[2] = LTR_D;
    do_clear();
    for (int i = 0; i < 12; i++)
      sb.push_back(mk(1, 8'(i / 4 + 1), ltrs[i / 4], 2'(i / 4), 0, 0));
    sb.push_back(mk(1, 8'd1, LTR_B, 0, 0, 0));
    for (int i = 0; i < 13; i++) begin
      if (i < 3) set_write(1, 8'(i + 1), ltrs[i]);
      tick();
      set_write(0, 8'h00, 4'h0);
      e = sb.pop_front();
      o = observe();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL three_rot cyc%0d: got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_overflow();
    exp_t e, o;
    do_clear();
    for (int i = 0; i < 16; i++)
      sb.push_back(mk(1, 8'((i / 4 + 1) * 10), LTR_P, 2'(i / 4), i >= 3, i >= 4));
    sb.push_back(mk(1, 8'd10, LTR_P, 0, 1, 1));
    for (int i = 0; i < 17; i++) begin
      if (i < 5) set_write(1, 8'((i + 1) * 10), LTR_P);
      tick();
      set_write(0, 8'h00, 4'h0);
      e = sb.pop_front();
      o = observe();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL overflow cyc%0d: got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_hold();
    exp_t e, o;
    do_clear();
    for (int i = 0; i < 14; i++) sb.push_back(mk(1, 8'd1, LTR_E, 0, 0, 0));
    for (int i = 14; i < 18; i++) sb.push_back(mk(1, 8'd2, LTR_F, 1, 0, 0));
    sb.push_back(mk(1, 8'd1, LTR_E, 0, 0, 0));
    for (int i = 0; i < 19; i++) begin
      if (i == 0) set_write(1, 8'd1, LTR_E);
      if (i == 1) set_write(1, 8'd2, LTR_F);
      hold = (i >= 2 && i <= 11);
      tick();
      set_write(0, 8'h00, 4'h0);
      e = sb.pop_front();
      o = observe();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL hold cyc%0d: got %h want %h", i, o, e);
      end
    end
    hold = 1'b0;
  endtask

  task automatic test_clear_write();
    exp_t e, o;
    do_clear();
    for (int i = 0; i < 4; i++) sb.push_back(mk(1, 8'd1, LTR_C, 0, 0, 0));
    for (int i = 4; i < 6; i++) sb.push_back(mk(1, 8'd2, LTR_C, 1, 0, 0));
    for (int i = 6; i < 9; i++) sb.push_back(mk(0, 8'h00, LTR_BLANK, 0, 0, 0));
    for (int i = 9; i < 13; i++) sb.push_back(mk(1, 8'd5, LTR_D, 0, i == 12, 0));
    for (int i = 0; i < 13; i++) begin
      if (i < 3) set_write(1, 8'(i + 1), LTR_C);
      if (i == 6) begin
        set_write(1, 8'd99, LTR_A);
        clear = 1'b1;
      end
      if (i >= 9) set_write(1, 8'(i - 4), LTR_D);
      tick();
      set_write(0, 8'h00, 4'h0);
      clear = 1'b0;
      e = sb.pop_front();
      o = observe();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL clear_write cyc%0d: got %h want %h", i, o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    exp_t e, o;
    do_clear();
    for (int i = 0; i < 3; i++) sb.push_back(mk(1, 8'd7, LTR_A, 0, 0, 0));
    for (int i = 3; i < 5; i++) sb.push_back(mk(0, 8'h00, LTR_BLANK, 0, 0, 0));
    for (int i = 5; i < 7; i++) sb.push_back(mk(1, 8'd9, LTR_B, 0, 0, 0));
    for (int i = 0; i < 7; i++) begin
      if (i == 0) set_write(1, 8'd7, LTR_A);
      if (i == 1) set_write(1, 8'd8, LTR_A);
      if (i == 5) set_write(1, 8'd9, LTR_B);
      reset = (i == 3);
      tick();
      set_write(0, 8'h00, 4'h0);
      reset = 1'b0;
      e = sb.pop_front();
      o = observe();
      tests_run++;
      if (o !== e) begin
        tests_failed++;
        $display("FAIL reset_mid cyc%0d: got %h want %h", i, o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_three();
    test_overflow();
    test_hold();
    test_clear_write();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
